i2c_txn_ctrl: RTL

Transaction sequencer that sits between a register-access client and the byte-level I2C master engine. It accepts one register write or register read request at a time. It then drives the engine's command lines (i2c_en, i2c_start, i2c_stop, i2c_ack, tx_data) through the full sequence: S, addr, reg, data, P for a write; S, addr+W, reg, Sr, addr+R, N bytes, P for a read. Read bytes are returned as a stream, and a completion status is reported per transaction, including slave NACK.

---
 rtl/i2c_pkg.sv | 47 ++++
 rtl/i2c_txn_ctrl_if.sv | 46 ++++
 rtl/i2c_txn_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and encodings for the I2C transaction sequencer.
//   ctrl_state_t : sequencer FSM states
//   phase_t      : which bus phase the currently preset engine command belongs to
//   CMD_*        : {start,stop} command encodings presented to the byte engine
//   ST_*         : completion status codes reported with resp_done
package i2c_pkg;

  typedef enum logic [2:0] {
    C_IDLE, C_LAUNCH, C_WAIT_HOLD, C_WAIT_TX, C_CHK_ACK, C_WAIT_RX, C_WAIT_IDLE, C_DONE
  } ctrl_state_t;

  typedef enum logic [2:0] {
    PH_DEV_W, PH_REG, PH_WDATA, PH_RSTART, PH_DEV_R, PH_RD, PH_STOP
  } phase_t;

  localparam logic [1:0] CMD_WRITE  = 2'b00;
  localparam logic [1:0] CMD_RSTART = 2'b10;
  localparam logic [1:0] CMD_STOP   = 2'b01;
  localparam logic [1:0] CMD_READ   = 2'b11;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_NACK_ADDR = 2'b01;
  localparam logic [1:0] ST_NACK_DATA = 2'b10;
  localparam logic [1:0] ST_TIMEOUT   = 2'b11;

  // {start,stop} pair the engine expects for a given phase
  function automatic logic [1:0] phase_cmd(phase_t ph);
    case (ph)
      PH_RSTART: return CMD_RSTART;
      PH_STOP:   return CMD_STOP;
      PH_RD:     return CMD_READ;
      default:   return CMD_WRITE;
    endcase
  endfunction

  // Phase that follows an acknowledged transmitted byte
  function automatic phase_t phase_after_tx(phase_t ph, logic rw);
    case (ph)
      PH_DEV_W: return PH_REG;
      PH_REG:   return rw ? PH_RSTART : PH_WDATA;
      PH_WDATA: return PH_STOP;
      PH_DEV_R: return PH_RD;
      default:  return PH_STOP;
    endcase
  endfunction

endpackage

// File: rtl/i2c_txn_ctrl_if.sv
// i2c_txn_ctrl_if: client request/response and byte-engine command/status bundle.
//   master modport : the transaction sequencer (drives req_ready, responses, engine commands)
//   slave modport  : the environment (client + byte engine)
// Client side : req_valid/ready, req_rw, req_dev, req_reg, req_wdata, req_len,
//               rd_data, rd_valid, resp_done, resp_status, busy
// Engine side : m_i2c_en/start/stop/ack, m_tx_data (commands);
//               m_tx_done, m_tx_ready, m_rx_done, m_rx_data (status)
interface i2c_txn_ctrl_if #(
  parameter int LEN_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_rw;
  logic [6:0]       req_dev;
  logic [7:0]       req_reg;
  logic [7:0]       req_wdata;
  logic [LEN_W-1:0] req_len;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             resp_done;
  logic [1:0]       resp_status;
  logic             busy;
  logic             m_i2c_en;
  logic             m_i2c_start;
  logic             m_i2c_stop;
  logic             m_i2c_ack;
  logic [7:0]       m_tx_data;
  logic             m_tx_done;
  logic             m_tx_ready;
  logic             m_rx_done;
  logic [7:0]       m_rx_data;

  modport master (
    input  req_valid, req_rw, req_dev, req_reg, req_wdata, req_len,
           m_tx_done, m_tx_ready, m_rx_done, m_rx_data,
    output req_ready, rd_data, rd_valid, resp_done, resp_status, busy,
           m_i2c_en, m_i2c_start, m_i2c_stop, m_i2c_ack, m_tx_data
  );

  modport slave (
    output req_valid, req_rw, req_dev, req_reg, req_wdata, req_len,
           m_tx_done, m_tx_ready, m_rx_done, m_rx_data,
    input  req_ready, rd_data, rd_valid, resp_done, resp_status, busy,
           m_i2c_en, m_i2c_start, m_i2c_stop, m_i2c_ack, m_tx_data
  );
endinterface

// File: rtl/i2c_txn_ctrl.sv
// i2c_txn_ctrl: sequences one register write (S,addr+W,reg,data,P) or register
// read (S,addr+W,reg,Sr,addr+R,N bytes,P) through a byte-level I2C engine.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (shared with the engine)
//   bus (master) : client request/response and engine command/status signals
// Parameters:
//   LEN_W        : read length field width; a length of 0 reads one byte
//   TIMEOUT_CYC  : per-wait-state watchdog limit, present only with
//                  I2C_TXN_CTRL_TIMEOUT_EN defined (watchdog reports status 11)
// Engine commands are preset one phase ahead and consumed by the engine on any
// cycle where it shows m_tx_ready while we are busy (outside C_LAUNCH).
module i2c_txn_ctrl
  import i2c_pkg::*;
#(
  parameter int LEN_W = 4
`ifdef I2C_TXN_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 65535
`endif
) (
  input logic            clk,
  input logic            reset,
  i2c_txn_ctrl_if.master bus
);

  ctrl_state_t      state, state_nxt;
  phase_t           phase, phase_nxt;
  logic [LEN_W-1:0] rem, rem_nxt;
  logic [1:0]       st_q, st_nxt;
  logic             preset, consume, rx_take, accept;
  logic             rw_q;
  logic [6:0]       dev_q, dev_src;
  logic [7:0]       reg_q, wdata_q, preset_data;

`ifdef I2C_TXN_CTRL_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        to_hit;
  assign to_hit = (state inside {C_WAIT_HOLD, C_WAIT_TX, C_WAIT_RX, C_WAIT_IDLE}) &&
                  (to_cnt >= 32'(TIMEOUT_CYC));
`endif

  assign bus.req_ready = (state == C_IDLE) & bus.m_tx_ready;
  assign bus.busy      = (state != C_IDLE);
  assign accept        = bus.req_valid & bus.req_ready;
  // DEV_W is preset in the accept cycle, before the request is captured
  assign dev_src       = accept ? bus.req_dev : dev_q;

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    rem_nxt   = rem;
    st_nxt    = st_q;
    preset    = 1'b0;
    consume   = 1'b0;
    rx_take   = 1'b0;
    case (state)
      C_IDLE: if (accept) begin
        state_nxt = C_LAUNCH;
        phase_nxt = PH_DEV_W;
        preset    = 1'b1;
        rem_nxt   = (bus.req_len == '0) ? LEN_W'(1) : bus.req_len;
        st_nxt    = ST_OK;
      end
      C_LAUNCH:    state_nxt = C_WAIT_HOLD;
      C_WAIT_HOLD: consume = bus.m_tx_ready;
      C_CHK_ACK: begin
        if (bus.m_tx_ready) consume = 1'b1;
        else begin
          // phase already advanced: REG/RD follow an address byte
          st_nxt    = (phase == PH_REG || phase == PH_RD) ? ST_NACK_ADDR : ST_NACK_DATA;
          state_nxt = C_WAIT_IDLE;
        end
      end
      C_WAIT_TX: if (bus.m_tx_done) begin
        phase_nxt = phase_after_tx(phase, rw_q);
        preset    = 1'b1;
        state_nxt = C_CHK_ACK;
      end
      C_WAIT_RX: if (bus.m_rx_done) begin
        rx_take   = 1'b1;
        rem_nxt   = rem - LEN_W'(1);
        phase_nxt = (rem_nxt == '0) ? PH_STOP : PH_RD;
        preset    = 1'b1;
        state_nxt = C_WAIT_HOLD;
      end
      C_WAIT_IDLE: if (bus.m_tx_ready) state_nxt = C_DONE;
      C_DONE:      state_nxt = C_IDLE;
      default:     state_nxt = C_IDLE;
    endcase
    // engine took the preset command this cycle
    if (consume) begin
      case (phase)
        PH_RD:     state_nxt = C_WAIT_RX;
        PH_STOP:   state_nxt = C_WAIT_IDLE;
        PH_RSTART: begin
          state_nxt = C_WAIT_HOLD;
          phase_nxt = PH_DEV_R;
          preset    = 1'b1;
        end
        default:   state_nxt = C_WAIT_TX;
      endcase
    end
`ifdef I2C_TXN_CTRL_TIMEOUT_EN
    if (to_hit) begin
      state_nxt = C_DONE;
      st_nxt    = ST_TIMEOUT;
      phase_nxt = phase;
      rem_nxt   = rem;
      preset    = 1'b0;
      rx_take   = 1'b0;
    end
`endif
  end

  always_comb begin
    case (phase_nxt)
      PH_DEV_W: preset_data = {dev_src, 1'b0};
      PH_REG:   preset_data = reg_q;
      PH_WDATA: preset_data = wdata_q;
      PH_DEV_R: preset_data = {dev_q, 1'b1};
      default:  preset_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= C_IDLE;
      phase           <= PH_DEV_W;
      rem             <= '0;
      st_q            <= ST_OK;
      rw_q            <= 1'b0;
      dev_q           <= '0;
      reg_q           <= '0;
      wdata_q         <= '0;
      bus.m_i2c_en    <= 1'b0;
      bus.m_i2c_start <= 1'b0;
      bus.m_i2c_stop  <= 1'b0;
      bus.m_i2c_ack   <= 1'b0;
      bus.m_tx_data   <= '0;
      bus.rd_data     <= '0;
      bus.rd_valid    <= 1'b0;
      bus.resp_done   <= 1'b0;
      bus.resp_status <= ST_OK;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      rem   <= rem_nxt;
      st_q  <= st_nxt;
      if (accept) begin
        rw_q    <= bus.req_rw;
        dev_q   <= bus.req_dev;
        reg_q   <= bus.req_reg;
        wdata_q <= bus.req_wdata;
      end
      bus.m_i2c_en <= (state_nxt == C_LAUNCH);
      if (preset) begin
        {bus.m_i2c_start, bus.m_i2c_stop} <= phase_cmd(phase_nxt);
        bus.m_tx_data <= preset_data;
        // ACK every read byte except the last
        bus.m_i2c_ack <= (phase_nxt == PH_RD) && (rem_nxt > LEN_W'(1));
      end
      bus.rd_valid <= rx_take;
      if (rx_take) bus.rd_data <= bus.m_rx_data;
      bus.resp_done <= (state_nxt == C_DONE);
      if (state_nxt == C_DONE) bus.resp_status <= st_nxt;
    end
  end

`ifdef I2C_TXN_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   to_cnt <= '0;
    else if (state_nxt != state) to_cnt <= '0;
    else                         to_cnt <= to_cnt + 32'd1;
  end
`endif

endmodule
